// File: rtl/mul_serial.sv
// Iterative radix-2 shift-add multiplier with a start/done handshake.
// Signed operands are reduced to magnitudes up front and the sign is restored in FIX.
module mul_serial #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic                  sign,
  input  logic [DATA_W-1:0]     multiplicand,
  input  logic [DATA_W-1:0]     multiplier,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Handshake: start is honoured only on an edge where done=1; done drops on
  // that edge and rises again on the edge that writes the new product.
  state_t                state;
  logic [2*DATA_W-1:0]   mcand;
  logic [DATA_W-1:0]     mplier;
  logic [2*DATA_W-1:0]   acc;
  logic [CNT_W-1:0]      cnt;
  logic                  neg;

  logic [DATA_W-1:0]     mag_a;
  logic [DATA_W-1:0]     mag_b;

  // The most-negative input negates to itself, which is its correct magnitude.
  assign mag_a = (sign && multiplicand[DATA_W-1]) ? (~multiplicand + 1'b1) : multiplicand;
  assign mag_b = (sign && multiplier[DATA_W-1])   ? (~multiplier + 1'b1)   : multiplier;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      done    <= 1'b1;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{DATA_W{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sign & (multiplicand[DATA_W-1] ^ multiplier[DATA_W-1]);
            done   <= 1'b0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          product <= neg ? (~acc + 1'b1) : acc;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_serial.sv
// Bench for mul_serial: cycle-level reference model checked every cycle,
// plus directed operations with hand-computed products.
module tb_mul_serial;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic            clk;
  logic            rst;
  logic            start;
  logic            done;
  logic            sign;
  logic [W-1:0]    multiplicand;
  logic [W-1:0]    multiplier;
  logic [2*W-1:0]  product;

  int n_cmp;
  int n_err;

  mul_serial #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done         (done),
    .sign         (sign),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic [2*W-1:0] r;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      r  = sa * sb;
    end else begin
      r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    return r;
  endfunction

  // Model: a job accepted when idle finishes LAT edges later.
  logic [2*W-1:0] exp_q[$];
  int             m_busy;
  logic [2*W-1:0] m_prod;
  bit             chk_en;

  always @(posedge clk) begin
    if (!rst) begin
      m_busy = 0;
      m_prod = '0;
      exp_q.delete();
      chk_en = 1'b1;
    end else if (m_busy == 0) begin
      if (start) begin
        exp_q.push_back(ref_mul(sign, multiplicand, multiplier));
        m_busy = LAT;
      end
    end else begin
      m_busy = m_busy - 1;
      if (m_busy == 0 && exp_q.size() > 0) m_prod = exp_q.pop_front();
    end
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("done_vs_model", {{(2*W-1){1'b0}}, done}, {{(2*W-1){1'b0}}, (m_busy == 0)});
      chk("product_vs_model", product, m_prod);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    if (lat >= 100) chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit clobber, output int lat);
    sign         = s;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (clobber) begin
      multiplicand = '0;
      multiplier   = '0;
      sign         = 1'b0;
    end
    wait_done(lat);
  endtask

  task automatic op_lit(input string name, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int lat;
    run_op(s, a, b, 1'b0, lat);
    chk(name, product, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int gap;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_cmp = 0;
    n_err = 0;
    chk_en = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    sign = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_done", {63'd0, done}, 64'd1);
      chk("idle_product", product, 64'd0);
    end

    // Unsigned max, with operands clobbered after the start edge.
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
    chk("u_max_product", product, 64'hFFFF_FFFE_0000_0001);
    chk("u_max_latency", 64'(lat), 64'd33);

    op_lit("s_m7x3", 1'b1, 32'hFFFF_FFF9, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB);
    op_lit("s_min_sq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op_lit("s_min_x1", 1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
    op_lit("u_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op_lit("u_12x10", 1'b0, 32'd12, 32'd10, 64'd120);

    run_op(1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0, lat);
    chk("zero_a_product", product, 64'd0);
    chk("zero_a_latency", 64'(lat), 64'd33);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, lat);
    chk("zero_b_product", product, 64'd0);
    chk("zero_b_latency", 64'(lat), 64'd33);

    // Start pulsed while busy is ignored; previous product held through CALC.
    op_lit("prev_7x6", 1'b0, 32'd7, 32'd6, 64'd42);
    sign = 1'b0; multiplicand = 32'd3; multiplier = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_in_calc", product, 64'd42);
    multiplicand = 32'd5; multiplier = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("held_in_calc2", product, 64'd42);
    wait_done(lat);
    chk("busy_start_ignored", product, 64'd12);
    @(negedge clk);
    chk("no_queued_op", {63'd0, done}, 64'd1);

    // Start held high: one launch every LAT+1 cycles.
    sign = 1'b0; multiplicand = 32'd2; multiplier = 32'd3; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      while (done !== 1'b1 && gap < 100) begin gap++; @(negedge clk); end
      while (done === 1'b1 && gap < 100) begin gap++; @(negedge clk); end
      chk("b2b_period", 64'(gap), 64'd34);
      chk("b2b_product", product, 64'd6);
    end
    start = 1'b0;
    wait_done(lat);

    // Reset mid-CALC aborts with no partial result.
    run_op(1'b0, 32'd9, 32'd9, 1'b0, lat);
    sign = 1'b0; multiplicand = 32'd100; multiplier = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_done", {63'd0, done}, 64'd1);
    chk("rst_mid_product", product, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_stays", product, 64'd0);

    // Random regression, both sign modes.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 100; i++) begin
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 15) == 0) ra = '0;
        if ($urandom_range(0, 15) == 0) rb = '0;
        run_op(s[0], ra, rb, $urandom_range(0, 1) == 1, lat);
        chk("rand_product", product, ref_mul(s[0], ra, rb));
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
